mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mips32_mem_pkg.sv | 24 ++
 rtl/mem_responder_if.sv | 32 +++
 rtl/mem_resp_array.sv | 55 +++++
 rtl/mem_responder.sv | 138 +++++++++++++
 tb/tb_mem_responder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_mem_pkg
//  Description : Shared widths, LW/SW opcode constants and the responder
//                state enumeration for the mem_responder slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips32_mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    // MIPS32 primary opcodes of the two transactions this responder serves
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : Request/response handshake bundle between an initiator
//                (master) and the memory responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
    import mips32_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/mem_resp_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_resp_array
//  Description : Single-port word storage, synchronous write, registered
//                read. Contents are not touched by reset; only the read
//                register is cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_resp_array
    import mips32_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              en,
    input  wire logic              we,
    input  wire logic [AW-1:0]     addr,
    input  wire logic [DATA_W-1:0] wdata,
    output logic      [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] Mem [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Read register keeps its value unless a load is performed
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = Mem[addr];
        end
    end

    // Storage write; deliberately no reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (en && we) begin
            Mem[addr] <= wdata;
        end
    end

    // Read data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Memory responder for LW/SW requests. Accepts one request
//                in IDLE, waits WAIT_CYCLES wait states, performs the
//                storage access on the edge entering RESP and holds the
//                response until the initiator takes it.
//                Optional macro MEM_RESPONDER_RANGE_CHECK_EN: addresses
//                >= DEPTH report rsp_err and leave storage untouched.
//                Without it, addresses wrap modulo DEPTH (power of two).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic        c1,
    input  wire logic        rst_n,
    mem_responder_if.slave   bus
);
    import mips32_mem_pkg::*;

    localparam int AW = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              w_req_err;
    logic              w_mem_en;
    logic              w_mem_we;
    logic [AW-1:0]     w_mem_idx;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_mem_rdata;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    assign w_req_err = (bus.req_addr >= 32'(DEPTH));
`else
    // Upper address bits are dropped by the modulo-DEPTH wrap
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = |bus.req_addr[ADDR_W-1:AW];
    assign w_req_err        = 1'b0;
`endif

    // Next-state, request capture and storage access strobe
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        w_mem_en    = 1'b0;
        w_mem_we    = we_q;
        w_mem_idx   = idx_q;
        w_mem_wdata = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    idx_d   = bus.req_addr[AW-1:0];
                    wdata_d = bus.req_wdata;
                    err_d   = w_req_err;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: access happens on the accept edge
                        state_d     = ST_RESP;
                        w_mem_en    = !w_req_err;
                        w_mem_we    = bus.req_we;
                        w_mem_idx   = bus.req_addr[AW-1:0];
                        w_mem_wdata = bus.req_wdata;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    // Counter hits zero on this edge: enter RESP and access
                    state_d  = ST_RESP;
                    w_mem_en = !err_q;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-request registers
    always_ff @(posedge c1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    mem_resp_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (c1),
        .rst_n (rst_n),
        .en    (w_mem_en),
        .we    (w_mem_we),
        .addr  (w_mem_idx),
        .wdata (w_mem_wdata),
        .rdata (w_mem_rdata)
    );

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_err   = (state_q == ST_RESP) && err_q;
    // Load data only; stores and errored accesses answer with zero
    assign bus.rsp_rdata = ((state_q == ST_RESP) && !we_q && !err_q) ? w_mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. Two instances:
//                dut  (WAIT_CYCLES=2) and dut0 (WAIT_CYCLES=0), both
//                DEPTH=1024, checked against a word-array reference model.
//                Honours MEM_RESPONDER_RANGE_CHECK_EN for expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic c1;
    logic rst_n;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] ref_a [0:1023];
    logic [31:0] ref_b [0:1023];

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .c1    (c1),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .c1    (c1),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial c1 = 1'b0;
    always #5 c1 = ~c1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // {req_ready, rsp_valid, rsp_err, rsp_rdata}
    function automatic logic [34:0] sample(input bit sel);
        if (sel) return {bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_err, bus_b.rsp_rdata};
        return {bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_rdata};
    endfunction

    task automatic drive(input bit sel, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = a; bus_b.req_wdata = d;
        end else begin
            bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = a; bus_a.req_wdata = d;
        end
    endtask

    task automatic set_rr(input bit sel, input logic r);
        if (sel) bus_b.rsp_ready = r;
        else     bus_a.rsp_ready = r;
    endtask

    // Reference model: word array, range check or wrap, returns expectation
    function automatic void model(input bit sel, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] er, output logic ee);
        int idx;
        bit oob;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        oob = (addr >= 32'd1024);
`else
        oob = 1'b0;
`endif
        idx = int'(addr % 32'd1024);
        ee  = oob;
        er  = '0;
        if (!oob) begin
            if (we) begin
                if (sel) ref_b[idx] = wd;
                else     ref_a[idx] = wd;
            end else begin
                er = sel ? ref_b[idx] : ref_a[idx];
            end
        end
    endfunction

    // One full transaction, called at a negedge with the DUT in IDLE
    task automatic do_txn(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold);
        logic [31:0] er;
        logic        ee;
        logic [34:0] s;
        int          n;
        int          lat;
        lat = sel ? 1 : 3;
        model(sel, we, addr, wd, er, ee);
        drive(sel, 1'b1, we, addr, wd);
        set_rr(sel, 1'b0);
        s = sample(sel);
        chk("req_ready_idle", 32'(s[34]), 32'd1);
        @(posedge c1);
        @(negedge c1);
        drive(sel, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        n = 1;
        s = sample(sel);
        while (!s[33] && n <= 20) begin
            chk("req_ready_wait", 32'(s[34]), 32'd0);
            @(negedge c1);
            n++;
            drive(sel, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            s = sample(sel);
        end
        chk("latency", 32'(n), 32'(lat));
        for (int h = 0; h <= hold; h++) begin
            s = sample(sel);
            chk("rsp_valid", 32'(s[33]), 32'd1);
            chk("req_ready_resp", 32'(s[34]), 32'd0);
            chk("rsp_rdata", s[31:0], er);
            chk("rsp_err", 32'(s[32]), 32'(ee));
            if (h < hold) begin
                drive(sel, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                @(negedge c1);
            end
        end
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        set_rr(sel, 1'b1);
        @(negedge c1);
        s = sample(sel);
        chk("rsp_valid_done", 32'(s[33]), 32'd0);
        chk("req_ready_done", 32'(s[34]), 32'd1);
        set_rr(sel, 1'b0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] er1, er2;
        logic        ee1, ee2;
        logic [34:0] s;
        logic [31:0] ra;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        set_rr(1'b0, 1'b0);
        set_rr(1'b1, 1'b0);

        // Random preload of both storages, mirrored into the model
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            dut.u_array.Mem[i] = v;
            ref_a[i] = v;
            v = $urandom;
            dut0.u_array.Mem[i] = v;
            ref_b[i] = v;
        end
        dut.u_array.Mem[120] = 32'd85;
        ref_a[120] = 32'd85;

        // Reset state
        @(negedge c1);
        for (int k = 0; k < 2; k++) begin
            s = sample(k[0]);
            chk("rst_req_ready", 32'(s[34]), 32'd1);
            chk("rst_rsp_valid", 32'(s[33]), 32'd0);
            chk("rst_rsp_err", 32'(s[32]), 32'd0);
            chk("rst_rsp_rdata", s[31:0], 32'd0);
        end
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
        @(negedge c1);
        rst_n = 1'b1;
        @(negedge c1);

        // Preloaded load, latency 3
        do_txn(1'b0, 1'b0, 32'd120, 32'd0, 0);
        // Store then load back, plus storage inspection
        do_txn(1'b0, 1'b1, 32'd121, 32'd130, 1);
        do_txn(1'b0, 1'b0, 32'd121, 32'd0, 0);
        chk("mem121", dut.u_array.Mem[121], 32'd130);
        // Back-pressure: response held for 5 cycles
        do_txn(1'b0, 1'b0, 32'd120, 32'd0, 5);
        // Boundary address
        do_txn(1'b0, 1'b0, 32'd1024, 32'd0, 0);
        do_txn(1'b1, 1'b0, 32'd1024, 32'd0, 0);
        do_txn(1'b0, 1'b1, 32'd1025, 32'd99, 0);
        do_txn(1'b0, 1'b0, 32'd1, 32'd0, 0);

        // Reset during WAIT aborts a pending store
        drive(1'b0, 1'b1, 1'b1, 32'd5, 32'd7);
        @(posedge c1);
        @(negedge c1);
        s = sample(1'b0);
        chk("wait_rsp_valid", 32'(s[33]), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        s = sample(1'b0);
        chk("abort_req_ready", 32'(s[34]), 32'd1);
        chk("abort_rsp_valid", 32'(s[33]), 32'd0);
        chk("abort_rsp_err", 32'(s[32]), 32'd0);
        chk("abort_rsp_rdata", s[31:0], 32'd0);
        @(negedge c1);
        @(negedge c1);
        rst_n = 1'b1;
        @(negedge c1);
        do_txn(1'b0, 1'b0, 32'd5, 32'd0, 0);

        // Zero wait states: request presented while previous response completes
        model(1'b1, 1'b0, 32'd200, 32'd0, er1, ee1);
        drive(1'b1, 1'b1, 1'b0, 32'd200, 32'd0);
        @(posedge c1);
        @(negedge c1);
        s = sample(1'b1);
        chk("b2b_first_valid", 32'(s[33]), 32'd1);
        chk("b2b_first_rdata", s[31:0], er1);
        model(1'b1, 1'b0, 32'd300, 32'd0, er2, ee2);
        drive(1'b1, 1'b1, 1'b0, 32'd300, 32'd0);
        set_rr(1'b1, 1'b1);
        chk("b2b_req_ready_resp", 32'(s[34]), 32'd0);
        @(negedge c1);
        s = sample(1'b1);
        chk("b2b_idle_valid", 32'(s[33]), 32'd0);
        chk("b2b_idle_ready", 32'(s[34]), 32'd1);
        set_rr(1'b1, 1'b0);
        @(negedge c1);
        s = sample(1'b1);
        chk("b2b_second_valid", 32'(s[33]), 32'd1);
        chk("b2b_second_rdata", s[31:0], er2);
        chk("b2b_second_err", 32'(s[32]), 32'(ee2));
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        set_rr(1'b1, 1'b1);
        @(negedge c1);
        s = sample(1'b1);
        chk("b2b_done_valid", 32'(s[33]), 32'd0);
        set_rr(1'b1, 1'b0);

        // Randomised traffic on both instances, small address window for reuse
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 7) == 0) ra = $urandom;
            else                           ra = 32'($urandom_range(0, 15));
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                   $urandom, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
